stage_memory: RTL and testbench

Memory-access stage directly downstream of the execute stage; consumes its registered mem_* bundle.
- Performs loads and stores over a simple req/ack data bus.
- Resolves branches and jumps into a fetch redirect.
- Drives forwarding data and registers the write-back bundle.
- Asserts mem_stall back to execute while a bus access is outstanding.

---
 rtl/stage_memory_pkg.sv | 19 +
 rtl/stage_memory_if.sv | 21 ++
 rtl/stage_memory_load_align.sv | 26 ++
 rtl/stage_memory.sv | 182 ++++++++++++++++++
 tb/tb_stage_memory.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_memory_pkg.sv
// Shared codes for the memory-access stage: access widths, fault causes and
// bus FSM states.
package stage_memory_pkg;

  localparam logic [1:0] MEM_WIDTH_B = 2'd0;
  localparam logic [1:0] MEM_WIDTH_H = 2'd1;
  localparam logic [1:0] MEM_WIDTH_W = 2'd2;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_WIDTH    = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/stage_memory_if.sv
// Data-memory req/ack bus between the memory stage (master) and the data
// memory (slave).
interface stage_memory_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/stage_memory_load_align.sv
// Shifts the addressed lane of a read word down to bit 0, then masks it to the
// access width and sign- or zero-extends.
module stage_memory_load_align
  import stage_memory_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  width_i,
  input  logic        extend_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (width_i)
      MEM_WIDTH_B: data_o = {{24{extend_i & shifted[7]}}, shifted[7:0]};
      MEM_WIDTH_H: data_o = {{16{extend_i & shifted[15]}}, shifted[15:0]};
      default:     data_o = shifted;
    endcase
  end

endmodule

// File: rtl/stage_memory.sv
// Memory-access stage: load/store over the req/ack bus, branch resolution,
// forwarding data and the registered write-back bundle.
module stage_memory
  import stage_memory_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 16,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           mem_valid,
  input  logic [31:0]    mem_pc,
  input  logic [31:0]    mem_data0,
  input  logic [31:0]    mem_data1,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic           mem_extend,
  input  logic [1:0]     mem_width,
  input  logic           mem_jmp,
  input  logic           mem_br,
  input  logic           mem_br_inv,
  input  logic [4:0]     wb_reg,
  output logic           mem_stall,
  output logic [31:0]    mem_forward_data,
  output logic           mem_wen,
  output logic           br_taken,
  output logic [31:0]    br_target,
  stage_memory_if.master dmem,
  output logic           mem_fault,
  output logic [1:0]     mem_fault_cause,
  output logic [31:0]    mem_fault_pc,
  output logic           wb_valid,
  output logic [4:0]     wb_reg_r,
  output logic [31:0]    wb_data
);

  mem_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  logic        ldst, width_ok, misaligned, access, timeout_hit;
  logic        req_c, stall_c, fault_c, advance, wb_valid_d;
  logic [1:0]  off, cause_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, ld_data, fwd_c;

  logic        wb_valid_q, fault_q;
  logic [4:0]  wb_reg_q;
  logic [31:0] wb_data_q, fault_pc_q;
  logic [1:0]  fault_cause_q;

  assign off        = mem_data0[1:0];
  assign ldst       = mem_valid & (mem_read | mem_write);
  assign width_ok   = (mem_width != 2'd3);
  assign misaligned = CHECK_ALIGN & (((mem_width == MEM_WIDTH_H) & off[0]) |
                                     ((mem_width == MEM_WIDTH_W) & (off != 2'd0)));
  assign access     = ldst & width_ok & ~misaligned;
  // A late ack still completes the access: the timeout only fires without one.
  assign timeout_hit = (TIMEOUT != 0) & (state_q == ST_WAIT) &
                       (cnt_q == TIMEOUT) & ~dmem.dmem_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (access & ~dmem.dmem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = 32'd1;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (~access | dmem.dmem_ack | timeout_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Gating with reset_n drops the request the moment reset asserts mid-access.
  always_comb begin
    req_c   = access & ~timeout_hit & reset_n;
    stall_c = access & ~dmem.dmem_ack & ~timeout_hit;
  end

  always_comb begin
    case (mem_width)
      MEM_WIDTH_B: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{mem_data1[7:0]}};
      end
      MEM_WIDTH_H: begin
        be_c    = 4'b0011 << off;
        wdata_c = {2{mem_data1[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = mem_data1;
      end
    endcase
  end

  stage_memory_load_align u_load_align (
    .rdata_i  (dmem.dmem_rdata),
    .offset_i (off),
    .width_i  (mem_width),
    .extend_i (mem_extend),
    .data_o   (ld_data)
  );

  always_comb begin
    fault_c = 1'b1;
    cause_c = CAUSE_NONE;
    if (ldst & ~width_ok)      cause_c = CAUSE_WIDTH;
    else if (ldst & misaligned) cause_c = CAUSE_MISALIGN;
    else if (timeout_hit)       cause_c = CAUSE_TIMEOUT;
    else                        fault_c = 1'b0;
  end

  assign fwd_c      = mem_read ? ld_data : mem_data0;
  assign advance    = mem_valid & ~stall_c;
  assign wb_valid_d = advance & ~fault_c & ~mem_write & ~mem_br & (wb_reg != 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q    <= 1'b0;
      wb_reg_q      <= '0;
      wb_data_q     <= '0;
      fault_q       <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
      fault_pc_q    <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      if (advance) begin
        wb_reg_q  <= wb_reg;
        wb_data_q <= fwd_c;
      end
      fault_q <= fault_c;
      if (fault_c) begin
        fault_cause_q <= cause_c;
        fault_pc_q    <= mem_pc;
      end
    end
  end

  assign dmem.dmem_req   = req_c;
  assign dmem.dmem_we    = mem_write;
  assign dmem.dmem_addr  = {mem_data0[31:2], 2'b00};
  assign dmem.dmem_be    = be_c;
  assign dmem.dmem_wdata = wdata_c;

  assign mem_stall        = stall_c;
  assign mem_forward_data = fwd_c;
  assign mem_wen          = advance & ~mem_write & ~mem_br & (wb_reg != 5'd0);
  assign br_taken         = mem_valid & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)));
  assign br_target        = {mem_data1[31:1], 1'b0};
  assign mem_fault        = fault_q;
  assign mem_fault_cause  = fault_cause_q;
  assign mem_fault_pc     = fault_pc_q;
  assign wb_valid         = wb_valid_q;
  assign wb_reg_r         = wb_reg_q;
  assign wb_data          = wb_data_q;

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: a per-cycle behavioural model plus
// hand-computed expectations for each scenario.
module tb_stage_memory;
  import stage_memory_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, mem_read, mem_write, mem_extend, mem_jmp, mem_br, mem_br_inv;
  logic [31:0] mem_pc, mem_data0, mem_data1;
  logic [1:0]  mem_width;
  logic [4:0]  wb_reg;
  logic        mem_stall, mem_wen, br_taken, mem_fault, wb_valid;
  logic [31:0] mem_forward_data, br_target, mem_fault_pc, wb_data;
  logic [1:0]  mem_fault_cause;
  logic [4:0]  wb_reg_r;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  stage_memory_if bus ();

  stage_memory #(.TIMEOUT(TMO), .CHECK_ALIGN(1'b1)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_valid        (mem_valid),
    .mem_pc           (mem_pc),
    .mem_data0        (mem_data0),
    .mem_data1        (mem_data1),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_extend       (mem_extend),
    .mem_width        (mem_width),
    .mem_jmp          (mem_jmp),
    .mem_br           (mem_br),
    .mem_br_inv       (mem_br_inv),
    .wb_reg           (wb_reg),
    .mem_stall        (mem_stall),
    .mem_forward_data (mem_forward_data),
    .mem_wen          (mem_wen),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .dmem             (bus),
    .mem_fault        (mem_fault),
    .mem_fault_cause  (mem_fault_cause),
    .mem_fault_pc     (mem_fault_pc),
    .wb_valid         (wb_valid),
    .wb_reg_r         (wb_reg_r),
    .wb_data          (wb_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference load: pick the lane, keep the width, extend arithmetically.
  function automatic logic [31:0] m_load(logic [31:0] rd, logic [1:0] a, logic [1:0] w, logic ext);
    logic [31:0] s, v;
    s = rd >> (8 * a);
    if (w == 2'd0) begin
      v = s % 256;
      if (ext && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      v = s % 65536;
      if (ext && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = s;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(logic [1:0] w, logic [1:0] a);
    logic [3:0] b;
    int size;
    size = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    for (int i = 0; i < 4; i++) b[i] = (i >= int'(a)) && (i < int'(a) + size);
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] w, logic [31:0] d1);
    if (w == 2'd0) return {24'b0, d1[7:0]} * 32'h0101_0101;
    if (w == 2'd1) return {16'b0, d1[15:0]} * 32'h0001_0001;
    return d1;
  endfunction

  // Model state: expected registered outputs and cycles the current access has waited.
  logic        e_wbv = 1'b0, e_flt = 1'b0;
  logic [31:0] e_wbd = '0, e_fpc = '0;
  logic [4:0]  e_wbr = '0;
  logic [1:0]  e_fc  = '0;
  int          age   = 0;

  always @(negedge clk) begin : cmp
    logic        ldst, ill, mis, acc, tmo, stl, flt, brt, wen;
    logic [1:0]  a, cause;
    logic [31:0] fwd;
    a    = mem_data0[1:0];
    ldst = mem_valid && (mem_read || mem_write);
    ill  = ldst && (mem_width == 2'd3);
    mis  = ldst && !ill && ((mem_width == 2'd1 && a % 2 == 1) || (mem_width == 2'd2 && a != 0));
    acc  = ldst && !ill && !mis;
    tmo  = acc && (age == TMO) && !bus.dmem_ack;
    stl  = acc && !bus.dmem_ack && !tmo;
    fwd  = mem_read ? m_load(bus.dmem_rdata, a, mem_width, mem_extend) : mem_data0;
    brt  = mem_valid && (mem_jmp || (mem_br && (mem_data0[0] != mem_br_inv)));
    wen  = mem_valid && !stl && !mem_write && !mem_br && (wb_reg != 0);
    check("m_stall", 32'(mem_stall), 32'(stl));
    check("m_br_taken", 32'(br_taken), 32'(brt));
    check("m_br_target", br_target, mem_data1 & 32'hFFFF_FFFE);
    check("m_fwd", mem_forward_data, fwd);
    check("m_wen", 32'(mem_wen), 32'(wen));
    if (!reset_n) begin
      check("m_rst_req", 32'(bus.dmem_req), 32'd0);
      check("m_rst_wbv", 32'(wb_valid), 32'd0);
      check("m_rst_flt", 32'(mem_fault), 32'd0);
      e_wbv = 1'b0; e_wbd = '0; e_wbr = '0; e_flt = 1'b0; e_fc = '0; e_fpc = '0;
      age = 0;
    end else begin
      check("m_req", 32'(bus.dmem_req), 32'(acc && !tmo));
      if (acc && !tmo) begin
        check("m_we", 32'(bus.dmem_we), 32'(mem_write));
        check("m_addr", bus.dmem_addr, mem_data0 - 32'(a));
        check("m_be", 32'(bus.dmem_be), 32'(m_be(mem_width, a)));
        check("m_wdata", bus.dmem_wdata, m_wdata(mem_width, mem_data1));
      end
      check("m_wb_valid", 32'(wb_valid), 32'(e_wbv));
      check("m_wb_data", wb_data, e_wbd);
      check("m_wb_reg", 32'(wb_reg_r), 32'(e_wbr));
      check("m_fault", 32'(mem_fault), 32'(e_flt));
      check("m_fault_cause", 32'(mem_fault_cause), 32'(e_fc));
      check("m_fault_pc", mem_fault_pc, e_fpc);
      flt   = ill || mis || tmo;
      cause = ill ? 2'd3 : mis ? 2'd1 : tmo ? 2'd2 : 2'd0;
      if (mem_valid && !stl) begin
        e_wbv = !flt && !mem_write && !mem_br && (wb_reg != 0);
        e_wbd = fwd;
        e_wbr = wb_reg;
      end else begin
        e_wbv = 1'b0;
      end
      e_flt = flt;
      if (flt) begin
        e_fc  = cause;
        e_fpc = mem_pc;
      end
      age = (acc && stl) ? age + 1 : 0;
    end
  end

  task automatic idle_inputs();
    mem_valid = 0; mem_read = 0; mem_write = 0; mem_extend = 0; mem_jmp = 0;
    mem_br = 0; mem_br_inv = 0; mem_pc = '0; mem_data0 = '0; mem_data1 = '0;
    mem_width = 2'd0; wb_reg = '0; bus.dmem_rdata = '0; bus.dmem_ack = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  initial begin
    int stalls, reqs;
    reset_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    sample();
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_fault", 32'(mem_fault), 32'd0);
    check("rst_req", 32'(bus.dmem_req), 32'd0);
    @(posedge clk); #1 reset_n = 1;

    // zero-wait word load
    cyc(); mem_valid = 1; mem_read = 1; mem_width = 2; mem_data0 = 32'h100; mem_pc = 32'h10;
    wb_reg = 5; bus.dmem_rdata = 32'hDEAD_BEEF; bus.dmem_ack = 1;
    sample();
    check("lw_stall", 32'(mem_stall), 32'd0);
    check("lw_req", 32'(bus.dmem_req), 32'd1);
    cyc(); sample();
    check("lw_wb_valid", 32'(wb_valid), 32'd1);
    check("lw_wb_data", wb_data, 32'hDEAD_BEEF);
    check("lw_wb_reg", 32'(wb_reg_r), 32'd5);

    // byte store, ack on the fourth cycle
    cyc(); mem_valid = 1; mem_write = 1; mem_width = 0; mem_data0 = 32'h103;
    mem_data1 = 32'h0000_00A5; mem_pc = 32'h14; wb_reg = 7;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      bus.dmem_ack = (i == 3);
      sample();
      if (i == 0) begin
        check("sb_be", 32'(bus.dmem_be), 32'b1000);
        check("sb_wdata", bus.dmem_wdata, 32'hA5A5_A5A5);
      end
      if (mem_stall) stalls++;
    end
    check("sb_stall_cycles", 32'(stalls), 32'd3);
    cyc(); sample();
    check("sb_wb_valid", 32'(wb_valid), 32'd0);

    // signed then unsigned byte load
    cyc(); mem_valid = 1; mem_read = 1; mem_width = 0; mem_extend = 1; mem_data0 = 32'h102;
    wb_reg = 3; bus.dmem_rdata = 32'h0080_0000; bus.dmem_ack = 1;
    cyc(); mem_valid = 1; mem_read = 1; mem_width = 0; mem_extend = 0; mem_data0 = 32'h102;
    wb_reg = 3; bus.dmem_rdata = 32'h0080_0000; bus.dmem_ack = 1;
    sample();
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    cyc(); sample();
    check("lbu_wb_data", wb_data, 32'h0000_0080);

    // misaligned half load
    cyc(); mem_valid = 1; mem_read = 1; mem_width = 1; mem_extend = 1; mem_data0 = 32'h101;
    mem_pc = 32'h40; wb_reg = 4;
    sample();
    check("lh_mis_req", 32'(bus.dmem_req), 32'd0);
    cyc(); sample();
    check("lh_mis_fault", 32'(mem_fault), 32'd1);
    check("lh_mis_cause", 32'(mem_fault_cause), 32'd1);
    check("lh_mis_pc", mem_fault_pc, 32'h40);
    check("lh_mis_wbv", 32'(wb_valid), 32'd0);
    cyc(); sample();
    check("lh_mis_pulse", 32'(mem_fault), 32'd0);

    // illegal width store
    cyc(); mem_valid = 1; mem_write = 1; mem_width = 3; mem_data0 = 32'h200; mem_pc = 32'h44;
    sample();
    check("ill_req", 32'(bus.dmem_req), 32'd0);
    cyc(); sample();
    check("ill_cause", 32'(mem_fault_cause), 32'd3);

    // bus timeout
    cyc(); mem_valid = 1; mem_read = 1; mem_width = 2; mem_data0 = 32'h200; mem_pc = 32'h50; wb_reg = 9;
    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (bus.dmem_req) reqs++;
      if (!mem_stall) break;
    end
    check("tmo_released", 32'(mem_stall), 32'd0);
    check("tmo_req_cycles", 32'(reqs), 32'd16);
    check("tmo_req_drop", 32'(bus.dmem_req), 32'd0);
    cyc(); sample();
    check("tmo_fault", 32'(mem_fault), 32'd1);
    check("tmo_cause", 32'(mem_fault_cause), 32'd2);
    check("tmo_pc", mem_fault_pc, 32'h50);
    check("tmo_wbv", 32'(wb_valid), 32'd0);

    // reset asserted while waiting for ack
    cyc(); mem_valid = 1; mem_read = 1; mem_width = 2; mem_data0 = 32'h300; wb_reg = 9;
    repeat (3) @(negedge clk);
    #2 reset_n = 0;
    #1 check("rst_mid_req", 32'(bus.dmem_req), 32'd0);
    cyc();
    @(posedge clk); #1 reset_n = 1;

    // branches and jump link
    cyc(); mem_valid = 1; mem_br = 1; mem_br_inv = 1; mem_data0 = 32'h0; mem_data1 = 32'h2001; mem_pc = 32'h60;
    sample();
    check("br_taken", 32'(br_taken), 32'd1);
    check("br_target", br_target, 32'h2000);
    cyc(); mem_valid = 1; mem_br = 1; mem_br_inv = 1; mem_data0 = 32'h1; mem_data1 = 32'h2001;
    sample();
    check("br_not_taken", 32'(br_taken), 32'd0);
    cyc(); mem_valid = 1; mem_jmp = 1; mem_pc = 32'h3000; mem_data0 = 32'h3004; mem_data1 = 32'h5000; wb_reg = 1;
    sample();
    check("jmp_target", br_target, 32'h5000);
    cyc(); sample();
    check("jmp_wbv", 32'(wb_valid), 32'd1);
    check("jmp_link", wb_data, 32'h3004);

    // half store and signed half load at offset 2
    cyc(); mem_valid = 1; mem_write = 1; mem_width = 1; mem_data0 = 32'h102; mem_data1 = 32'h1234_BEEF;
    bus.dmem_ack = 1;
    sample();
    check("sh_be", 32'(bus.dmem_be), 32'b1100);
    check("sh_wdata", bus.dmem_wdata, 32'hBEEF_BEEF);
    cyc(); mem_valid = 1; mem_read = 1; mem_width = 1; mem_extend = 1; mem_data0 = 32'h102;
    wb_reg = 2; bus.dmem_rdata = 32'h8001_0000; bus.dmem_ack = 1;
    cyc(); sample();
    check("lh_wb_data", wb_data, 32'hFFFF_8001);

    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
